// File: rtl/twpm_wb_mailbox.sv
// twpm_wb_mailbox: Wishbone mailbox sharing one command RAM between WB and DP ports, with exec/complete handshake and W1C IRQs
module twpm_wb_mailbox #(
  parameter int          RAM_ADDR_WIDTH        = 11,
  parameter int          LOCALITY_WIDTH        = 4,
  parameter int          COMPLETE_PULSE_WIDTH  = 20,
  parameter logic [16:0] FPGA_RAM_BASE_ADDRESS = 17'h00800,
  parameter logic [31:0] DEFAULT_READ_VALUE    = 32'hBADFABAC
) (
  input  logic                      WB_CLK,
  input  logic                      WB_RST,
  input  logic [16:0]               WBs_ADR,
  input  logic                      WBs_CYC,
  input  logic                      WBs_STB,
  input  logic                      WBs_WE,
  input  logic [3:0]                WBs_BYTE_STB,
  input  logic [31:0]               WBs_WR_DAT,
  output logic [31:0]               WBs_RD_DAT,
  output logic                      WBs_ACK,
  input  logic                      exec_i,
  input  logic                      abort_i,
  input  logic [3:0]                op_type_i,
  input  logic [LOCALITY_WIDTH-1:0] locality_i,
  input  logic [RAM_ADDR_WIDTH-1:0] buf_len_i,
  input  logic [RAM_ADDR_WIDTH-1:0] dp_addr_i,
  input  logic                      dp_wr_i,
  input  logic [7:0]                dp_data_i,
  output logic [7:0]                dp_data_o,
  output logic [RAM_ADDR_WIDTH-3:0] ram_addr_o,
  output logic [31:0]               ram_wd_o,
  output logic [3:0]                ram_wen_o,
  input  logic [31:0]               ram_rd_i,
  output logic                      exec_o,
  output logic                      complete_o,
  output logic                      irq_o
);
  localparam int AW = RAM_ADDR_WIDTH;
  localparam int CW = $clog2(COMPLETE_PULSE_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CMD, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d, sts_q, sts_d, en_q, en_d;
  logic [LOCALITY_WIDTH-1:0] loc_q, loc_d;
  logic [AW-1:0] len_q, len_d;
  logic [31:0] rd_q, rd_d, reg_rd;
  logic [1:0] lane_q;
  logic exec_q, ack_q, rp_q, rden_q, dpd_q;
  logic owner, req, in_ram, ram_req, reg_req, reg_wr, cmpl_wr, rise, unused;
  logic [14:0] wa;
  assign unused = ^WBs_ADR[1:0];
  assign owner = state_q == CMD;
  // no new request while a read is pending or its ACK is on the bus
  assign req = WBs_CYC & WBs_STB & ~ack_q & ~rp_q;
  assign in_ram = WBs_ADR[16:AW] == FPGA_RAM_BASE_ADDRESS[16:AW];
  assign wa = WBs_ADR[16:2];
  assign ram_req = req & in_ram;
  assign reg_req = req & ~in_ram;
  assign reg_wr = reg_req & WBs_WE;
  assign cmpl_wr = reg_wr & (wa == 15'h10);
  assign rise = exec_i & ~exec_q;
  assign exec_o = owner;
  assign complete_o = cnt_q != '0;
  assign irq_o = |(sts_q & en_q);
  assign WBs_RD_DAT = rd_q;
  assign WBs_ACK = ack_q;
  assign ram_addr_o = owner ? WBs_ADR[AW-1:2] : dp_addr_i[AW-1:2];
  assign ram_wd_o = owner ? WBs_WR_DAT : {4{dp_data_i}};
  assign ram_wen_o = WB_RST ? 4'b0 : owner ? ({4{ram_req & WBs_WE}} & WBs_BYTE_STB)
                                           : ({4{dp_wr_i}} & (4'b1 << dp_addr_i[1:0]));
  assign dp_data_o = WB_RST ? 8'h00 : dpd_q ? 8'hFF : ram_rd_i[{lane_q, 3'b000} +: 8];
  always_comb begin
    reg_rd = wa == 15'h0  ? {28'b0, state_q == DONE, abort_i, exec_o, complete_o} :
             wa == 15'h1  ? {28'b0, op_q} :
             wa == 15'h2  ? 32'(loc_q) :
             wa == 15'h3  ? 32'(len_q) :
             wa == 15'h4  ? {28'b0, sts_q} :
             wa == 15'h5  ? {28'b0, en_q} :
             wa == 15'h10 ? 32'b0 : DEFAULT_READ_VALUE;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    loc_d = loc_q;
    len_d = len_q;
    if (state_q == IDLE && rise) begin
      state_d = CMD;
      op_d = op_type_i;
      loc_d = locality_i;
      len_d = buf_len_i;
    end
    if (state_q == CMD && cmpl_wr) begin
      state_d = DONE;
      cnt_d = CW'(COMPLETE_PULSE_WIDTH);
    end
    if (state_q == DONE) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = IDLE;
    end
  end
  // clear first, then OR in this cycle's events so a same-cycle set survives W1C
  always_comb begin
    sts_d = (sts_q & ~({4{reg_wr & (wa == 15'h4)}} & WBs_WR_DAT[3:0]))
          | {ram_req & ~owner, cmpl_wr & ~owner, abort_i & owner, rise & (state_q == IDLE)};
    en_d = (reg_wr & (wa == 15'h5)) ? WBs_WR_DAT[3:0] : en_q;
    rd_d = reg_req ? reg_rd : rp_q ? (rden_q ? DEFAULT_READ_VALUE : ram_rd_i) : rd_q;
  end
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      loc_q <= '0;
      len_q <= '0;
      sts_q <= '0;
      en_q <= '0;
      rd_q <= '0;
      exec_q <= 1'b0;
      ack_q <= 1'b0;
      rp_q <= 1'b0;
      rden_q <= 1'b0;
      lane_q <= '0;
      dpd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      loc_q <= loc_d;
      len_q <= len_d;
      sts_q <= sts_d;
      en_q <= en_d;
      rd_q <= rd_d;
      exec_q <= exec_i;
      ack_q <= reg_req | (ram_req & WBs_WE) | rp_q;
      rp_q <= ram_req & ~WBs_WE;
      rden_q <= ~owner;
      lane_q <= dp_addr_i[1:0];
      dpd_q <= owner;
    end
  end
endmodule

// File: tb/tb_twpm_wb_mailbox.sv
// tb_twpm_wb_mailbox: scoreboard bench for the mailbox, with a byte-array reference model and a behavioural RAM
module tb_twpm_wb_mailbox;
  localparam logic [31:0] DEF = 32'hBADFABAC;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [16:0] adr;
  logic cyc, stb, we, ack, exec, abort, dpwr, exec_o, cmpl, irq;
  logic [3:0] bstb, op, loc, rwen;
  logic [31:0] wdat, rdat, rwd, rrd;
  logic [10:0] len, dpa;
  logic [7:0] dpd, dpo;
  logic [8:0] ra;

  twpm_wb_mailbox dut (
    .WB_CLK(clk), .WB_RST(rst), .WBs_ADR(adr), .WBs_CYC(cyc), .WBs_STB(stb), .WBs_WE(we),
    .WBs_BYTE_STB(bstb), .WBs_WR_DAT(wdat), .WBs_RD_DAT(rdat), .WBs_ACK(ack),
    .exec_i(exec), .abort_i(abort), .op_type_i(op), .locality_i(loc), .buf_len_i(len),
    .dp_addr_i(dpa), .dp_wr_i(dpwr), .dp_data_i(dpd), .dp_data_o(dpo),
    .ram_addr_o(ra), .ram_wd_o(rwd), .ram_wen_o(rwen), .ram_rd_i(rrd),
    .exec_o(exec_o), .complete_o(cmpl), .irq_o(irq));

  logic [31:0] ram [512];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) if (rwen[k]) ram[ra][8*k +: 8] <= rwd[8*k +: 8];
    rrd <= ram[ra];
  end

  // reference model: byte-addressed buffer plus command phase 0=idle 1=cmd 2=done
  logic [7:0] mem [2048];
  int m_st;
  logic [3:0] m_sts, m_en, m_op, m_loc;
  logic [10:0] m_len;

  typedef struct { bit chk; logic [31:0] d; string nm; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic bit in_win(logic [16:0] a);
    return (a >> 11) == 17'd1;
  endfunction

  function automatic logic [31:0] model_rd(logic [16:0] a);
    int w;
    w = int'(a & 17'h7FC);
    if (in_win(a)) return m_st == 1 ? {mem[w+3], mem[w+2], mem[w+1], mem[w]} : DEF;
    case (a & 17'h1FFFC)
      17'h00: return {28'b0, m_st == 2, abort, m_st == 1, m_st == 2};
      17'h04: return {28'b0, m_op};
      17'h08: return {28'b0, m_loc};
      17'h0C: return {21'b0, m_len};
      17'h10: return {28'b0, m_sts};
      17'h14: return {28'b0, m_en};
      17'h40: return 32'b0;
      default: return DEF;
    endcase
  endfunction

  function automatic void model_wr(logic [16:0] a, logic [3:0] s, logic [31:0] d);
    int w;
    w = int'(a & 17'h7FC);
    if (in_win(a)) begin
      if (m_st == 1) begin
        for (int k = 0; k < 4; k++) if (s[k]) mem[w+k] = d[8*k +: 8];
      end else m_sts |= 4'h8;
    end else case (a & 17'h1FFFC)
      17'h10: m_sts &= ~d[3:0];
      17'h14: m_en = d[3:0];
      17'h40: if (m_st == 1) m_st = 2; else m_sts |= 4'h4;
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && ack) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected ACK: got rdat %h, expected no ACK", rdat);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk) chk(e.nm, rdat, e.d);
      end
    end
  end

  task automatic wb(input logic [16:0] a, input bit w, input logic [3:0] s, input logic [31:0] d,
                    input bit rise, input int lat, input string nm);
    exp_t e;
    int n;
    @(posedge clk) #1;
    adr = a; cyc = 1; stb = 1; we = w; bstb = s; wdat = d;
    if (rise) exec = 1;
    e.chk = !w; e.d = model_rd(a); e.nm = nm;
    q.push_back(e);
    if (w) model_wr(a, s, d);
    else if (in_win(a) && m_st != 1) m_sts |= 4'h8;
    if (rise && m_st == 0) begin
      m_st = 1; m_sts |= 4'h1; m_op = op; m_loc = loc; m_len = len;
    end
    n = 0;
    do begin
      @(posedge clk) #1;
      n++;
    end while (!ack && n < 10);
    if (!ack) begin
      tests++;
      fails++;
      $display("FAIL %s: got no ACK in %0d cycles, expected ACK", nm, n);
    end else chk({nm, " latency"}, 32'(n), 32'(lat));
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic dp_wr(input logic [10:0] a, input logic [7:0] d);
    @(posedge clk) #1;
    dpa = a; dpd = d; dpwr = 1;
    if (m_st != 1) mem[a] = d;
    @(posedge clk) #1;
    dpwr = 0;
  endtask

  task automatic dp_rd(input logic [10:0] a, input string nm);
    @(posedge clk) #1;
    dpa = a;
    @(posedge clk) #1;
    chk(nm, 32'(dpo), m_st == 1 ? 32'hFF : 32'(mem[a]));
  endtask

  task automatic do_exec(input logic [3:0] o, input logic [3:0] l, input logic [10:0] n);
    @(posedge clk) #1;
    exec = 0; op = o; loc = l; len = n;
    @(posedge clk) #1;
    exec = 1;
    @(posedge clk) #1;
    m_st = 1; m_sts |= 4'h1; m_op = o; m_loc = l; m_len = n;
  endtask

  task automatic finish_cmd(input string nm);
    int n;
    wb(17'h40, 1, 4'hF, $urandom, 0, 1, {nm, " COMPLETE"});
    n = 0;
    while (cmpl && n < 100) begin
      if (exec_o) chk({nm, " exec_o in pulse"}, 32'(exec_o), 0);
      n++;
      @(posedge clk) #1;
    end
    chk({nm, " pulse width"}, 32'(n), 32'd20);
    m_st = 0;
  endtask

  initial begin
    int b;
    logic [16:0] a;
    for (int i = 0; i < 512; i++) ram[i] = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 0;
    m_st = 0; m_sts = 0; m_en = 0; m_op = 0; m_loc = 0; m_len = 0;
    adr = 0; cyc = 0; stb = 0; we = 0; bstb = 0; wdat = 0;
    exec = 0; abort = 0; op = 0; loc = 0; len = 0; dpa = 0; dpwr = 0; dpd = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ack", 32'(ack), 0);
    chk("rst rdat", rdat, 0);
    chk("rst outs", {exec_o, cmpl, irq, rwen, dpo}, 0);
    rst = 0;
    wb(17'h000, 0, 4'hF, 0, 0, 1, "STATUS after reset");
    wb(17'h010, 0, 4'hF, 0, 0, 1, "IRQ_STATUS after reset");
    wb(17'h0FC, 0, 4'hF, 0, 0, 1, "unmapped 0x0FC");

    dp_wr(0, 8'hA1); dp_wr(1, 8'hB2); dp_wr(2, 8'hC3); dp_wr(3, 8'hD4);
    do_exec(3, 2, 4);
    wb(17'h000, 0, 4'hF, 0, 0, 1, "STATUS in CMD");
    wb(17'h004, 0, 4'hF, 0, 0, 1, "OP_TYPE");
    wb(17'h008, 0, 4'hF, 0, 0, 1, "LOCALITY");
    wb(17'h00C, 0, 4'hF, 0, 0, 1, "BUF_SIZE");
    wb(17'h800, 0, 4'hF, 0, 0, 2, "RAM read 0x800");
    wb(17'h800, 1, 4'b0011, 32'h11223344, 0, 1, "RAM write 0x800");
    dp_rd(1, "DP read in CMD");
    dp_wr(5, 8'h5A);
    finish_cmd("cmd1");
    chk("exec_o after cmd1", 32'(exec_o), 0);
    for (int i = 0; i < 4; i++) dp_rd(11'(i), "DP readback");
    dp_rd(5, "DP write in CMD dropped");

    wb(17'h014, 1, 4'hF, 32'h3, 0, 1, "IRQ_ENABLE write");
    chk("irq after enable", 32'(irq), 32'(|(m_sts & m_en)));
    do_exec(1, 1, 8);
    abort = 1;
    @(posedge clk) #1;
    abort = 0;
    m_sts |= 4'h2;
    chk("irq after abort", 32'(irq), 32'(|(m_sts & m_en)));
    wb(17'h010, 0, 4'hF, 0, 0, 1, "IRQ_STATUS after abort");
    wb(17'h010, 1, 4'hF, 32'h2, 0, 1, "W1C abort");
    wb(17'h010, 0, 4'hF, 0, 0, 1, "IRQ_STATUS after W1C");
    finish_cmd("cmd2");
    exec = 0; op = 4'h7; loc = 4'h9; len = 11'h123;
    @(posedge clk) #1;
    wb(17'h010, 1, 4'hF, 32'h1, 1, 1, "W1C during exec rise");
    wb(17'h010, 0, 4'hF, 0, 0, 1, "IRQ_STATUS set wins");
    wb(17'h000, 0, 4'hF, 0, 0, 1, "STATUS after rise+W1C");
    wb(17'h00C, 0, 4'hF, 0, 0, 1, "BUF_SIZE cmd3");
    finish_cmd("cmd3");
    exec = 0;

    wb(17'h040, 1, 4'hF, 0, 0, 1, "spurious COMPLETE");
    b = 0;
    repeat (5) begin
      @(posedge clk) #1;
      b |= int'(cmpl);
    end
    chk("no pulse on spurious", 32'(b), 0);
    wb(17'h804, 1, 4'hF, 32'hCAFEF00D, 0, 1, "denied RAM write");
    wb(17'h804, 0, 4'hF, 0, 0, 2, "denied RAM read");
    wb(17'h010, 0, 4'hF, 0, 0, 1, "IRQ_STATUS spurious+denied");
    for (int i = 4; i < 8; i++) dp_rd(11'(i), "DP after denied write");
    chk("irq final", 32'(irq), 32'(|(m_sts & m_en)));

    for (int r = 0; r < 6; r++) begin
      repeat (8) dp_wr(11'($urandom_range(0, 2047)), 8'($urandom));
      case ($urandom_range(0, 3))
        0: a = 17'h000;
        1: a = 17'h010;
        2: a = 17'h014;
        default: a = 17'h100 + 17'($urandom_range(0, 447) * 4);
      endcase
      wb(a, 0, 4'hF, 0, 0, 1, "rand reg read");
      do_exec(4'($urandom), 4'($urandom), 11'($urandom));
      wb(17'h004, 0, 4'hF, 0, 0, 1, "rand OP_TYPE");
      wb(17'h008, 0, 4'hF, 0, 0, 1, "rand LOCALITY");
      repeat (6) begin
        a = 17'h800 | 17'($urandom_range(0, 511) * 4);
        if ($urandom_range(0, 1) == 1) wb(a, 1, 4'($urandom), $urandom, 0, 1, "rand RAM write");
        else wb(a, 0, 4'hF, 0, 0, 2, "rand RAM read");
      end
      dp_wr(11'($urandom), 8'($urandom));
      dp_rd(11'($urandom), "rand DP read in CMD");
      wb(17'h010, 1, 4'hF, 32'($urandom_range(0, 15)), 0, 1, "rand W1C");
      wb(17'h014, 1, 4'hF, 32'($urandom_range(0, 15)), 0, 1, "rand IRQ_ENABLE");
      wb(17'h010, 0, 4'hF, 0, 0, 1, "rand IRQ_STATUS");
      chk("rand irq", 32'(irq), 32'(|(m_sts & m_en)));
      finish_cmd("rand cmd");
      repeat (6) dp_rd(11'($urandom), "rand DP read");
      wb(17'h800 | 17'($urandom_range(0, 511) * 4), 0, 4'hF, 0, 0, 2, "rand denied read");
    end

    do_exec(5, 3, 9);
    wb(17'h40, 1, 4'hF, 0, 0, 1, "COMPLETE before reset");
    repeat (13) @(posedge clk) #1;
    chk("pulse before reset", 32'(cmpl), 1);
    exec = 0;
    rst = 1;
    #1;
    chk("complete_o on reset", 32'(cmpl), 0);
    chk("exec_o on reset", 32'(exec_o), 0);
    chk("irq on reset", 32'(irq), 0);
    m_st = 0; m_sts = 0; m_en = 0; m_op = 0; m_loc = 0; m_len = 0;
    @(posedge clk) #1;
    rst = 0;
    wb(17'h000, 0, 4'hF, 0, 0, 1, "STATUS after mid reset");
    wb(17'h004, 0, 4'hF, 0, 0, 1, "OP_TYPE after mid reset");
    wb(17'h008, 0, 4'hF, 0, 0, 1, "LOCALITY after mid reset");
    wb(17'h00C, 0, 4'hF, 0, 0, 1, "BUF_SIZE after mid reset");
    wb(17'h010, 0, 4'hF, 0, 0, 1, "IRQ_STATUS after mid reset");
    repeat (3) @(posedge clk);
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/twpm_wb_mailbox.md
Name: twpm_wb_mailbox

Overview:
- Wishbone-slave mailbox between the Cortex-M4 fabric bridge and the TPM command path.
- Owns the shared command buffer: arbitrates a word-wide Wishbone port and a byte-wide data-provider (DP) port onto one synchronous single-port RAM.
- Tracks the command handshake: exec, then firmware complete, then a complete pulse.
- Adds latched command attributes, a sticky W1C interrupt/status register with enable mask, and access-denied error flags.

Parameters:
- RAM_ADDR_WIDTH, 11, byte address width of the buffer window (buffer = 2^RAM_ADDR_WIDTH bytes).
- LOCALITY_WIDTH, 4, width of the locality field.
- COMPLETE_PULSE_WIDTH, 20, complete_o high time in clocks (>=1); counter width clog2(COMPLETE_PULSE_WIDTH+1).
- FPGA_RAM_BASE_ADDRESS, 17'h00800, Wishbone base of the buffer window, aligned to 2^RAM_ADDR_WIDTH.
- DEFAULT_READ_VALUE, 32'hBADFABAC, read data for unmapped or denied accesses.

Ports:
- WB_CLK  in  1  sole clock.
- WB_RST  in  1  asynchronous, active-high reset.
- WBs_ADR  in  17  Wishbone byte address.
- WBs_CYC / WBs_STB / WBs_WE  in  1 each  Wishbone cycle, strobe and write enable.
- WBs_BYTE_STB  in  4  byte enables.
- WBs_WR_DAT  in  32  write data.
- WBs_RD_DAT  out  32  registered read data.
- WBs_ACK  out  1  one-cycle acknowledge.
- exec_i  in  1  command-start level from the register module.
- abort_i  in  1  abort request level.
- op_type_i  in  4  command type.
- locality_i  in  LOCALITY_WIDTH  command locality.
- buf_len_i  in  RAM_ADDR_WIDTH  command byte count.
- dp_addr_i  in  RAM_ADDR_WIDTH  DP byte address.
- dp_wr_i  in  1  DP byte write strobe.
- dp_data_i  in  8  DP write byte.
- dp_data_o  out  8  DP read byte, valid one cycle after the address.
- ram_addr_o  out  RAM_ADDR_WIDTH-2  RAM word address.
- ram_wd_o  out  32  RAM write data.
- ram_wen_o  out  4  RAM byte write enables, active high.
- ram_rd_i  in  32  RAM read data, one-cycle latency.
- exec_o  out  1  firmware owns the buffer.
- complete_o  out  1  complete pulse.
- irq_o  out  1  OR of (IRQ_STATUS & IRQ_ENABLE).

Behaviour:
- Reset: FSM=IDLE; pulse counter=0; IRQ_STATUS=0; IRQ_ENABLE=0; latched attributes=0; WBs_ACK=0; WBs_RD_DAT=0; exec_o=0; complete_o=0; irq_o=0; ram_wen_o=0; dp_data_o=0. Reset mid-command aborts the handshake silently; no complete pulse.

FSM:
- IDLE -> CMD on rising exec_i (exec_i=1, registered exec_q=0).
- On that edge, latch op_type_i, locality_i and buf_len_i, and set IRQ_STATUS[0] (EXEC_RISE).
- CMD -> DONE on an acknowledged WB write to 0x040 (data ignored); load the counter with COMPLETE_PULSE_WIDTH.
- DONE: counter decrements each clock; DONE -> IDLE when counter=1 (next value 0).
- exec_o = (state==CMD). complete_o = (counter!=0), giving exactly COMPLETE_PULSE_WIDTH cycles.
- exec_i edges outside IDLE are ignored; a still-high exec_i does not retrigger (edge-based).
- abort_i=1 in CMD sets IRQ_STATUS[1] (ABORT) each cycle it is high. The state is unchanged; firmware ends the command with a COMPLETE write.
- COMPLETE write in IDLE or DONE: no state change, counter not reloaded, sets IRQ_STATUS[2] (SPURIOUS_COMPLETE).

Wishbone:
- A request is accepted when CYC&STB and no access is in flight.
- Register access: ACK is registered, asserted in cycle N+1 for one cycle; RD_DAT is updated the same edge.
- RAM-window read: RAM address issued in cycle N; ram_rd_i captured into RD_DAT at end of N+1; ACK in N+2.
- RAM-window write: ram_wen_o=WBs_BYTE_STB in cycle N only; ACK in N+1.
- Register map (word-decoded on ADR[16:2]):
  - 0x000 STATUS RO {28'b0, state==DONE, abort_i, exec_o, complete_o}.
  - 0x004 OP_TYPE RO (latched).
  - 0x008 LOCALITY RO (latched).
  - 0x00C BUF_SIZE RO (latched).
  - 0x010 IRQ_STATUS W1C bits[3:0].
  - 0x014 IRQ_ENABLE RW bits[3:0].
  - 0x040 COMPLETE WO, reads 0.
  - Anything else reads DEFAULT_READ_VALUE; writes are ignored.
- A W1C clear and a set of the same bit in the same cycle: the set wins.

Buffer arbitration:
- Owner is WB in CMD, DP otherwise. Switching is registered with the FSM, so no enable glitches.
- Non-owner RAM writes are dropped. A WB RAM access when not owner returns DEFAULT_READ_VALUE, ACKs with normal timing, and sets IRQ_STATUS[3] (DENIED).
- DP access during CMD: write dropped, dp_data_o returns 8'hFF.
- DP write byte lane = dp_addr_i[1:0]. Little-endian: lane k drives ram_wd_o[8k+7:8k] and ram_wen_o[k]. dp_data_o is selected from ram_rd_i using the registered lane.
- Address beyond the window wraps modulo 2^RAM_ADDR_WIDTH.

Test Plan:
- Reset, then read STATUS/0x010/0x0FC: ACK after 1 cycle; data 0, 0, 32'hBADFABAC.
- DP writes 0xA1,0xB2,0xC3,0xD4 to 0..3; exec_i rises with op=3, loc=2, len=4 -> STATUS=0x2, LOCALITY=2, BUF_SIZE=4. WB read 0x800 = 32'hD4C3B2A1, ACK 2 cycles after request.
- In CMD, WB writes 0x800=32'h11223344 with BYTE_STB=4'b0011, then COMPLETE -> complete_o high exactly 20 cycles, exec_o=0. DP then reads bytes 0..3 = 44,33,C3,D4.
- IRQ_ENABLE=0x3, abort_i pulsed in CMD -> irq_o=1 and IRQ_STATUS=0x3. W1C 0x2 -> 0x1. W1C during a new exec rise -> bit0 stays set.
- COMPLETE write in IDLE -> IRQ_STATUS[2]=1, no pulse. WB write to 0x804 in IDLE -> RAM unchanged, IRQ_STATUS[3]=1.
- WB_RST asserted mid-DONE (counter=7) -> complete_o=0 immediately; state IDLE; latched fields 0.
